// File: rtl/ctrl_ulab_seq.sv
// Multicycle control sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB per instruction
// and drives the ALU operand selects and datapath enables from the current state.
module ctrl_ulab_seq #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state_q;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       op_known;
    logic       unused_inputs;

    // funct reaches the ALU decode directly; zero only matters to the PC write logic.
    assign unused_inputs = ^{funct, zero};
    assign wait_done     = (wait_cnt == WAIT_LAST);

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
            default:                                       op_known = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            // Counter restarts on every state change and only counts while a memory state holds.
            wait_cnt <= '0;
            case (state_q)
                S_FETCH: begin
                    if (wait_done) state_q <= S_DECODE;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      state_q <= S_EXEC_R;
                        OP_ADDI:       state_q <= S_EXEC_I;
                        OP_LW, OP_SW:  state_q <= S_MEM_ADDR;
                        OP_BEQ:        state_q <= S_BRANCH;
                        OP_J:          state_q <= S_JUMP;
                        default:       state_q <= S_FETCH;
                    endcase
                end
                S_EXEC_R:   state_q <= S_WB_R;
                S_WB_R:     state_q <= S_FETCH;
                S_EXEC_I:   state_q <= S_WB_I;
                S_WB_I:     state_q <= S_FETCH;
                S_MEM_ADDR: state_q <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (wait_done) state_q <= S_MEM_WB;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_MEM_WB:   state_q <= S_FETCH;
                S_MEM_WR: begin
                    if (wait_done) state_q <= S_FETCH;
                    else           wait_cnt <= wait_cnt + 3'd1;
                end
                S_BRANCH:   state_q <= S_FETCH;
                S_JUMP:     state_q <= S_FETCH;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch;
    // holding reset_n low blanks all outputs in the same cycle, even mid-access.
    always_comb begin
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        AluOp       = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        illegal     = 1'b0;
        state       = 4'd0;
        if (reset_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = 2'b01;
                    IRWrite = wait_done;
                    PCWrite = wait_done;
                end
                S_DECODE: begin
                    AluSrcB = 2'b11;
                    // The only opcode-dependent output: flags the DECODE cycle itself.
                    illegal = ~op_known;
                end
                S_EXEC_R: begin
                    AluSrcA = 1'b1;
                    AluOp   = 2'b10;
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                end
                S_WB_I:   RegWrite = 1'b1;
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    AluSrcA     = 1'b1;
                    AluOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: state = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_ulab_seq.sv
// Bench for ctrl_ulab_seq: three instances (MEM_WAIT 0, 2, 7) share random stimulus and
// are compared every cycle against an instruction-schedule model, plus literal checks.
module tb_ctrl_ulab_seq;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [3:0] st;
        logic       ill, m2r, rdst, rw, irw, mw, mr, iord;
        logic [1:0] pcs;
        logic       pcwc, pcw;
        logic [1:0] aop, asb;
        logic       asa;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       a_srca [NDUT];
    logic [1:0] a_srcb [NDUT];
    logic [1:0] a_op   [NDUT];
    logic       pcw    [NDUT];
    logic       pcwc   [NDUT];
    logic [1:0] pcsrc  [NDUT];
    logic       iord   [NDUT];
    logic       mrd    [NDUT];
    logic       mwr    [NDUT];
    logic       irw    [NDUT];
    logic       rw     [NDUT];
    logic       rdst   [NDUT];
    logic       m2r    [NDUT];
    logic       ill    [NDUT];
    logic [3:0] st     [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ctrl_ulab_seq #(.MEM_WAIT(g == 0 ? 0 : (g == 1 ? 2 : 7))) u_dut (
            .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
            .AluSrcA(a_srca[g]), .AluSrcB(a_srcb[g]), .AluOp(a_op[g]),
            .PCWrite(pcw[g]), .PCWriteCond(pcwc[g]), .PCSource(pcsrc[g]),
            .IorD(iord[g]), .MemRead(mrd[g]), .MemWrite(mwr[g]), .IRWrite(irw[g]),
            .RegWrite(rw[g]), .RegDst(rdst[g]), .MemToReg(m2r[g]),
            .illegal(ill[g]), .state(st[g])
        );
    end

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 7);
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    endfunction

    function automatic outs_t dut_outs(input int i);
        outs_t o;
        o.st = st[i];    o.ill = ill[i];   o.m2r = m2r[i];  o.rdst = rdst[i];
        o.rw = rw[i];    o.irw = irw[i];   o.mw = mwr[i];   o.mr = mrd[i];
        o.iord = iord[i]; o.pcs = pcsrc[i]; o.pcwc = pcwc[i]; o.pcw = pcw[i];
        o.aop = a_op[i]; o.asb = a_srcb[i]; o.asa = a_srca[i];
        return o;
    endfunction

    // Model: per instance, a queue of upcoming cycles (state id + "final FETCH cycle" flag),
    // extended a whole instruction phase at a time as opcodes become known.
    logic [3:0] m_st   [NDUT][32];
    bit         m_last [NDUT][32];
    int         m_head [NDUT];
    int         m_cnt  [NDUT];

    task automatic m_push(input int i, input logic [3:0] s, input bit last);
        int idx;
        idx = (m_head[i] + m_cnt[i]) % 32;
        m_st[i][idx]   = s;
        m_last[i][idx] = last;
        m_cnt[i]++;
    endtask

    task automatic m_push_fetch(input int i);
        for (int k = 0; k <= wait_of(i); k++) m_push(i, 4'd0, k == wait_of(i));
        m_push(i, 4'd1, 1'b0);
    endtask

    task automatic model_step(input int i);
        logic [3:0] s;
        if (!reset_n) begin
            m_head[i] = 0;
            m_cnt[i]  = 0;
            m_push_fetch(i);
            return;
        end
        s = m_st[i][m_head[i]];
        m_head[i] = (m_head[i] + 1) % 32;
        m_cnt[i]--;
        if (s == 4'd1) begin
            case (opcode)
                6'h00:        begin m_push(i, 4'd2, 1'b0); m_push(i, 4'd3, 1'b0); end
                6'h08:        begin m_push(i, 4'd4, 1'b0); m_push(i, 4'd5, 1'b0); end
                6'h23, 6'h2B: m_push(i, 4'd6, 1'b0);
                6'h04:        m_push(i, 4'd10, 1'b0);
                6'h02:        m_push(i, 4'd11, 1'b0);
                default:      ;
            endcase
        end else if (s == 4'd6) begin
            if (opcode == 6'h23) begin
                repeat (wait_of(i) + 1) m_push(i, 4'd7, 1'b0);
                m_push(i, 4'd8, 1'b0);
            end else begin
                repeat (wait_of(i) + 1) m_push(i, 4'd9, 1'b0);
            end
        end
        if (m_cnt[i] == 0) m_push_fetch(i);
    endtask

    function automatic outs_t exp_outs(input int i);
        outs_t e;
        logic [3:0] s;
        bit last;
        e = '0;
        if (!reset_n) return e;
        s    = m_st[i][m_head[i]];
        last = m_last[i][m_head[i]];
        e.st = s;
        case (s)
            4'd0:  begin e.mr = 1'b1; e.asb = 2'b01; e.irw = last; e.pcw = last; end
            4'd1:  begin e.asb = 2'b11; e.ill = !legal_op(opcode); end
            4'd2:  begin e.asa = 1'b1; e.aop = 2'b10; end
            4'd3:  begin e.rw = 1'b1; e.rdst = 1'b1; end
            4'd4:  begin e.asa = 1'b1; e.asb = 2'b10; end
            4'd5:  e.rw = 1'b1;
            4'd6:  begin e.asa = 1'b1; e.asb = 2'b10; end
            4'd7:  begin e.mr = 1'b1; e.iord = 1'b1; end
            4'd8:  begin e.rw = 1'b1; e.m2r = 1'b1; end
            4'd9:  begin e.mw = 1'b1; e.iord = 1'b1; end
            4'd10: begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; end
            4'd11: begin e.pcw = 1'b1; e.pcs = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NDUT; i++)
            check($sformatf("outputs dut%0d (wait %0d)", i, wait_of(i)),
                  64'(dut_outs(i)), 64'(exp_outs(i)));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset(input logic [5:0] op, input logic z);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        opcode  = op;
        zero    = z;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [39:0] sseq;
    logic [5:0]  bseq;
    logic [5:0]  flag_seq;
    logic        any_write;
    int          r;

    initial begin
        reset_n = 1'b0;
        opcode  = 6'h00;
        funct   = 6'h00;
        zero    = 1'b0;

        // R-type with MEM_WAIT=0: 0,1,2,3,0 and RegWrite only in WB_R
        apply_reset(6'h00, 1'b0);
        sseq = '0; bseq = '0; flag_seq = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sseq     = {sseq[35:0], st[0]};
            flag_seq = {flag_seq[4:0], rw[0]};
            if (k < 3) bseq = {bseq[3:0], a_srcb[0]};
        end
        check("rtype state sequence", sseq, 40'h01230);
        check("rtype AluSrcB sequence", bseq, 6'b011100);
        check("rtype RegWrite sequence", flag_seq, 6'b000010);

        // lw with MEM_WAIT=2: 3-cycle FETCH, 3-cycle MEM_RD, 9 cycles total
        apply_reset(6'h23, 1'b0);
        sseq = '0; flag_seq = '0; bseq = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sseq = {sseq[35:0], st[1]};
            if (k < 3)  flag_seq = {flag_seq[4:0], irw[1]};
            if (k == 4) bseq = {4'b0, a_srcb[1]};
        end
        check("lw wait2 state sequence", sseq, 40'h0001677780);
        check("lw wait2 IRWrite in FETCH", flag_seq, 6'b000001);
        check("lw wait2 AluSrcB in MEM_ADDR", bseq, 6'b000010);

        // sw on MEM_WAIT=7: opcode toggles to lw mid-MEM_WR, then reset cuts the write
        apply_reset(6'h2B, 1'b0);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (st[2] == 4'd9) break;
        end
        check("wait7 enters MEM_WR", st[2], 4'd9);
        @(posedge clk);
        #1;
        opcode = 6'h23;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wait7 stays MEM_WR after opcode change", {st[2], mwr[2]}, {4'd9, 1'b1});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("MemWrite drops as reset asserts", mwr[2], 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check("all outputs zero in reset", 64'(dut_outs(i)), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("FETCH after reset release", {st[2], mrd[2]}, {4'd0, 1'b1});

        // beq with zero=1 then zero=0: same path both times
        apply_reset(6'h04, 1'b1);
        sseq = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sseq = {sseq[35:0], st[0]};
            if (st[0] == 4'd10)
                check("BRANCH controls", {a_op[0], a_srcb[0], pcwc[0], pcsrc[0]}, 7'b01_00_1_01);
            if (k == 2) begin
                @(posedge clk);
                #1;
                zero = 1'b0;
            end
        end
        check("beq state sequence", sseq, 40'h01A01A);

        // unknown opcode: illegal pulses in DECODE only, no writes
        apply_reset(6'h3F, 1'b0);
        sseq = '0; flag_seq = '0; any_write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sseq     = {sseq[35:0], st[0]};
            flag_seq = {flag_seq[4:0], ill[0]};
            for (int i = 0; i < NDUT; i++) any_write = any_write | rw[i] | mwr[i];
        end
        check("illegal state sequence", sseq, 40'h010101);
        check("illegal pulse pattern", flag_seq, 6'b010101);
        check("no writes on illegal opcode", any_write, 1'b0);

        // random traffic: mostly legal opcodes, changing every cycle, rare resets
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            reset_n = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, 7);
            case (r)
                0: opcode = 6'h00;
                1: opcode = 6'h08;
                2: opcode = 6'h23;
                3: opcode = 6'h2B;
                4: opcode = 6'h04;
                5: opcode = 6'h02;
                default: opcode = 6'($urandom);
            endcase
            funct = 6'($urandom);
            zero  = 1'($urandom);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
